data_ram: RTL and testbench
===========================

# data_ram

Data-memory responder on the far end of the CPU's RAM port. Accepts the CPU's single-cycle `ram_read`/`ram_write` strobes with separate 6-bit read and write addresses, stores 64 words of 16 bits, and returns read data one cycle later with a valid pulse. After reset, it runs an initial clear sweep that zeroes every word. During the sweep it holds off the CPU with `ready`. It sits beside the CPU top-level, wired pin-for-pin to its RAM outputs.

## Interface
- `DEPTH`, 64, number of words; must equal 2**`ADDR_W`
- `ADDR_W`, 6, address width
- `DATA_W`, 16, word width
- `CLEAR_ON_RESET`, 1, 1 = zero all words after reset; 0 = skip the sweep
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-high
- `ram_read` input 1: read strobe, sampled each cycle
- `ram_write` input 1: write strobe, sampled each cycle
- `ram_read_addr` input `ADDR_W`: read address
- `ram_write_addr` input `ADDR_W`: write address
- `ram_data_out` input `DATA_W`: write data; the name follows the CPU's point of view
- `ram_data_in` output `DATA_W`: registered read data to the CPU
- `rd_valid` output 1: one-cycle pulse, `ram_data_in` updated this cycle
- `ready` output 1: high when strobes are accepted
- `Already decided`: one clock; reset is asynchronous and active-high (ports `clk`, `reset`)

## Operation
- **FSM states:** CLEAR, IDLE.
- **`reset` asserted:**
  - state goes to CLEAR if `CLEAR_ON_RESET`, otherwise IDLE
  - clear pointer = 0
  - `ram_data_in` = 0, `rd_valid` = 0, `ready` = 0
- **CLEAR:**
  - writes 0 to word [pointer] each cycle; pointer increments
  - after writing word `DEPTH`-1, goes to IDLE; the pointer is not wrapped
  - `ready` = 0 throughout
  - strobes are ignored: no write, no `rd_valid`
- **IDLE:**
  - `ready` = 1
  - `ram_write`: mem[`ram_write_addr`] <= `ram_data_out` at the clock edge
  - `ram_read`: `ram_data_in` <= mem[`ram_read_addr`] at the edge; `rd_valid` = 1 for the following cycle
- **Simultaneous read and write, same address:** write-first. The read returns `ram_data_out` (forwarded), not the old word.
- **Simultaneous read and write, different addresses:** both complete independently in the same cycle.
- **Back-to-back reads:** a read every cycle is accepted. `rd_valid` stays high continuously; each cycle carries the data for the previous cycle's address.
- **`ram_data_in` hold:** keeps its last value when no read occurs. Never cleared except by `reset`.
- **Reset mid-sweep or mid-operation:** the sweep restarts from word 0. Memory contents are not preserved when `CLEAR_ON_RESET` = 1; they are unspecified when it is 0.
- **Address width:** `ADDR_W` bits index the whole array with no out-of-range case. Addresses are ignored when the matching strobe is low.

## Timing
- **Write:** visible to a read issued in the same cycle (forwarding) and in any later cycle.
- **Read latency:** exactly 1 cycle, strobe edge to `ram_data_in`/`rd_valid`.
- **Sweep length:** `DEPTH` cycles after `reset` deasserts. `ready` rises on cycle `DEPTH`, counting the first post-reset edge as cycle 0.
- **With `CLEAR_ON_RESET` = 0:** `ready` = 1 from the first edge after reset release.
- **`ready` is combinational from state.** The CPU must not issue strobes while `ready` = 0; such strobes are dropped with no error flag.

## Structure
- **Shared `cpu_pkg`:**
  - `RAM_ADDR_W` = 6, `RAM_DATA_W` = 16, `RAM_DEPTH` = 64
  - enum `ram_state_t` {CLEAR, IDLE}
  - the CPU top-level uses the same constants for its RAM address/data widths
- **One sub-module, `ram_array`:** plain synchronous 1W/1R storage with no reset on the array. `data_ram` holds:
  - the FSM
  - the clear pointer
  - the write-data mux between sweep zero and `ram_data_out`
  - the forwarding comparator
  - the output register

## Test plan
- **Clear sweep:** reset, then wait. Require:
  - `ready` = 0 for 64 cycles, then 1
  - afterwards, reads of addresses 0, 31, 63 return 0x0000 with `rd_valid` one cycle later
- **Write then read:** write 0xBEEF to address 5; next cycle read address 5. Require `ram_data_in` = 0xBEEF and `rd_valid` = 1 one cycle after the read.
- **Same-cycle forwarding:** in one cycle, write 0x1234 to address 9 and read address 9. Require `ram_data_in` = 0x1234 next cycle. A concurrent write of 0xAAAA to 10 with a read of 11 (holding 0x5555) returns 0x5555.
- **Streaming reads:** after writes of 0x0001/0x0002/0x0003 to addresses 1/2/3, read 1, 2, 3 back-to-back. Require `rd_valid` high 3 consecutive cycles carrying 0x0001, 0x0002, 0x0003; afterwards `ram_data_in` holds 0x0003.
- **Strobes during sweep:** during the sweep, issue a write of 0xFFFF to address 60 and a read. Require:
  - no `rd_valid`
  - after the sweep, address 60 reads 0x0000
- **Reset mid-sweep:** assert `reset` at cycle 20 of the sweep. Require `ready` low again for a full 64 cycles, and all outputs 0 during reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Constants and types shared by the CPU top-level and its data RAM.
// The CPU sizes its RAM address/data buses from the same constants.
package cpu_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 16;
    localparam int RAM_DEPTH  = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_array.sv
// Plain 1W/1R storage: synchronous write, asynchronous read, no reset on the array.
// Registering of read data and forwarding are handled by the parent.
module ram_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_ram.sv
// Data-memory responder on the CPU RAM port: clear sweep after reset, then
// single-cycle write / one-cycle-latency read with write-first forwarding.
module data_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH          = RAM_DEPTH,
    parameter int ADDR_W         = RAM_ADDR_W,
    parameter int DATA_W         = RAM_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic [ADDR_W-1:0] ram_read_addr,
    input  logic [ADDR_W-1:0] ram_write_addr,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              rd_valid,
    output logic              ready
);

    localparam ram_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    ram_state_t        state_r;
    ram_state_t        state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic              started_r;
    logic              last_s;
    logic              ready_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;
    logic              fwd_s;
    logic [DATA_W-1:0] data_in_r;
    logic              rd_valid_r;

    assign last_s  = (ptr_r == ADDR_W'(DEPTH - 1));
    // started_r keeps ready low while reset is held even when the sweep is skipped
    assign ready_s = started_r & (state_r == IDLE);
    assign fwd_s   = ram_write & (ram_write_addr == ram_read_addr);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            CLEAR: begin
                if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            IDLE:    state_nxt_s = IDLE;
            default: state_nxt_s = RESET_STATE;
        endcase
    end

    // clear pointer: parks on the last word instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r     <= {ADDR_W{1'b0}};
            started_r <= 1'b0;
        end else begin
            started_r <= 1'b1;
            if ((state_r == CLEAR) && !last_s) begin
                ptr_r <= ptr_r + ADDR_W'(1);
            end
        end
    end

    // write-port mux between sweep zeroing and CPU writes
    always_comb begin
        we_s    = 1'b0;
        waddr_s = ram_write_addr;
        wdata_s = ram_data_out;
        if (state_r == CLEAR) begin
            we_s    = 1'b1;
            waddr_s = ptr_r;
            wdata_s = {DATA_W{1'b0}};
        end else begin
            we_s    = ready_s & ram_write;
        end
    end

    ram_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (ram_read_addr),
        .rdata (rdata_s)
    );

    // read-data output register; holds its value between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_in_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (ready_s && ram_read) begin
            data_in_r  <= fwd_s ? ram_data_out : rdata_s;
            rd_valid_r <= 1'b1;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    assign ram_data_in = data_in_r;
    assign rd_valid    = rd_valid_r;
    assign ready       = ready_s;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed steps from the test plan plus
// random traffic, compared against an array-based reference model.
module tb_data_ram;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_read;
    logic        ram_write;
    logic [5:0]  ram_read_addr;
    logic [5:0]  ram_write_addr;
    logic [15:0] ram_data_out;
    logic [15:0] ram_data_in;
    logic        rd_valid;
    logic        ready;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl_mem [64];
    logic [15:0] exp_data;
    logic        exp_valid;
    int          edges_since_reset;

    data_ram dut (
        .clk            (clk),
        .reset          (reset),
        .ram_read       (ram_read),
        .ram_write      (ram_write),
        .ram_read_addr  (ram_read_addr),
        .ram_write_addr (ram_write_addr),
        .ram_data_out   (ram_data_out),
        .ram_data_in    (ram_data_in),
        .rd_valid       (rd_valid),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_ready();
        return edges_since_reset >= RAM_DEPTH;
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [5:0] ra,
                         input logic [5:0] wa, input logic [15:0] wd);
        ram_read       = rd;
        ram_write      = wr;
        ram_read_addr  = ra;
        ram_write_addr = wa;
        ram_data_out   = wd;
    endtask

    // One clock: model the cycle (write first, then read), then compare outputs.
    task automatic step(input string tag);
        bit acc;
        acc = mdl_ready();
        if (acc && ram_write) mdl_mem[ram_write_addr] = ram_data_out;
        if (acc && ram_read) begin
            exp_data  = mdl_mem[ram_read_addr];
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        edges_since_reset++;
        check({tag, "_ready"}, {15'd0, ready}, {15'd0, mdl_ready()});
        check({tag, "_valid"}, {15'd0, rd_valid}, {15'd0, exp_valid});
        check({tag, "_data"}, ram_data_in, exp_data);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 16'd0);
        reset = 1'b1;
        #2;
        check("rst_data", ram_data_in, 16'h0000);
        check("rst_valid", {15'd0, rd_valid}, 16'd0);
        check("rst_ready", {15'd0, ready}, 16'd0);
        @(posedge clk);
        #1;
        check("rst_ready_held", {15'd0, ready}, 16'd0);
        reset = 1'b0;
        edges_since_reset = 0;
        for (int i = 0; i < 64; i++) mdl_mem[i] = 16'h0000;
        exp_data  = 16'h0000;
        exp_valid = 1'b0;
    endtask

    initial begin
        int low_cnt;
        logic [5:0] ra;
        logic [5:0] wa;
        logic [5:0] rd_addrs [4];

        reset = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 6'd0, 16'd0);
        do_reset();

        // sweep, with illegal strobes in the middle
        repeat (30) step("sweep");
        drive(1'b1, 1'b1, 6'd60, 6'd60, 16'hFFFF);
        step("sweep_strobe");
        drive(1'b0, 1'b0, 6'd0, 6'd0, 16'd0);
        step("sweep_after_strobe");
        check("no_valid_in_sweep", {15'd0, rd_valid}, 16'd0);
        while (edges_since_reset < 64) step("sweep");
        check("ready_after_sweep", {15'd0, ready}, 16'd1);

        // cleared words
        rd_addrs[0] = 6'd0; rd_addrs[1] = 6'd31; rd_addrs[2] = 6'd63; rd_addrs[3] = 6'd60;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, rd_addrs[i], 6'd0, 16'd0);
            step("clear_rd");
            check("clear_rd_zero", ram_data_in, 16'h0000);
            check("clear_rd_vld", {15'd0, rd_valid}, 16'd1);
        end

        // write then read
        drive(1'b0, 1'b1, 6'd0, 6'd5, 16'hBEEF);
        step("wr5");
        drive(1'b1, 1'b0, 6'd5, 6'd0, 16'd0);
        step("rd5");
        check("rd5_beef", ram_data_in, 16'hBEEF);

        // same-address forwarding, then independent different-address ops
        drive(1'b1, 1'b1, 6'd9, 6'd9, 16'h1234);
        step("fwd9");
        check("fwd9_1234", ram_data_in, 16'h1234);
        drive(1'b0, 1'b1, 6'd0, 6'd11, 16'h5555);
        step("wr11");
        drive(1'b1, 1'b1, 6'd11, 6'd10, 16'hAAAA);
        step("wr10_rd11");
        check("rd11_5555", ram_data_in, 16'h5555);
        drive(1'b1, 1'b0, 6'd10, 6'd0, 16'd0);
        step("rd10");
        check("rd10_aaaa", ram_data_in, 16'hAAAA);

        // streaming reads
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, 6'd0, 6'(i), 16'(i));
            step("stream_wr");
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 6'(i), 6'd0, 16'd0);
            step("stream_rd");
            check("stream_data", ram_data_in, 16'(i));
            check("stream_vld", {15'd0, rd_valid}, 16'd1);
        end
        drive(1'b0, 1'b0, 6'd0, 6'd0, 16'd0);
        step("hold");
        step("hold");
        check("hold_0003", ram_data_in, 16'h0003);

        // random traffic, biased toward address collisions
        for (int n = 0; n < 400; n++) begin
            wa = 6'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, wa,
                  16'($urandom));
            step("rand");
        end

        // reset mid-sweep
        do_reset();
        repeat (20) step("sweep2");
        do_reset();
        low_cnt = 0;
        while (!ready && low_cnt < 100) begin
            step("sweep3");
            low_cnt++;
        end
        check("resweep_len", 16'(low_cnt), 16'd64);
        for (int n = 0; n < 8; n++) begin
            drive(1'b1, 1'b0, 6'($urandom_range(0, 63)), 6'd0, 16'd0);
            step("post_reset_rd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
